// File: rtl/rtlcfg_cpubridge.sv
// Host-side access sequencer for the RAM-config CPU port: turns a one-cycle host
// request into a held upen window with a single strobe, a uprdy wait and a timeout.
module rtlcfg_cpubridge #(
   parameter int          ADDRBIT = 5,
   parameter int          WIDTH   = 32,
   parameter int          TOWIDTH = 6,
   parameter int          TIMEOUT = 40,
   parameter logic [31:0] TOVAL   = 32'hDEAD_0BAD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hcs,
   input  logic               hrnw,
   input  logic [ADDRBIT-1:0] haddr,
   input  logic [WIDTH-1:0]   hwdata,
   output logic [WIDTH-1:0]   hrdata,
   output logic               hack,
   output logic               herr,
   output logic               hbusy,
   output logic [7:0]         hdrop,
   input  logic               hdropclr,
   output logic               upen,
   output logic [ADDRBIT-1:0] upa,
   output logic               upws,
   output logic               uprs,
   output logic [WIDTH-1:0]   updi,
   input  logic [WIDTH-1:0]   updo,
   input  logic               uprdy
);

   localparam logic [WIDTH-1:0]   TO_DATA  = WIDTH'(TOVAL);
   localparam logic [TOWIDTH-1:0] CNT_LAST = TOWIDTH'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t               state, state_nxt;
   logic                 rnw, rnw_nxt;
   logic [TOWIDTH-1:0]   cnt, cnt_nxt;
   logic [ADDRBIT-1:0]   upa_nxt;
   logic [WIDTH-1:0]     updi_nxt, hrdata_nxt;
   logic                 upen_nxt, upws_nxt, uprs_nxt, hack_nxt, herr_nxt, hbusy_nxt;
   logic [7:0]           hdrop_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rnw    <= 1'b0;
         cnt    <= '0;
         upa    <= '0;
         updi   <= '0;
         hrdata <= '0;
         upen   <= 1'b0;
         upws   <= 1'b0;
         uprs   <= 1'b0;
         hack   <= 1'b0;
         herr   <= 1'b0;
         hbusy  <= 1'b0;
         hdrop  <= '0;
      end else begin
         state  <= state_nxt;
         rnw    <= rnw_nxt;
         cnt    <= cnt_nxt;
         upa    <= upa_nxt;
         updi   <= updi_nxt;
         hrdata <= hrdata_nxt;
         upen   <= upen_nxt;
         upws   <= upws_nxt;
         uprs   <= uprs_nxt;
         hack   <= hack_nxt;
         herr   <= herr_nxt;
         hbusy  <= hbusy_nxt;
         hdrop  <= hdrop_nxt;
      end
   end

   // Outputs are computed one cycle ahead so each is registered in the state it belongs to.
   always_comb begin
      state_nxt  = state;
      rnw_nxt    = rnw;
      cnt_nxt    = cnt;
      upa_nxt    = upa;
      updi_nxt   = updi;
      hrdata_nxt = hrdata;
      upen_nxt   = upen;
      upws_nxt   = 1'b0;
      uprs_nxt   = 1'b0;
      hack_nxt   = 1'b0;
      herr_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (hcs) begin
               upa_nxt   = haddr;
               updi_nxt  = hwdata;
               rnw_nxt   = hrnw;
               upen_nxt  = 1'b1;
               upws_nxt  = !hrnw;
               uprs_nxt  = hrnw;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            cnt_nxt   = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            // uprdy is checked first so a completion on the last wait cycle is not flagged
            if (uprdy) begin
               if (rnw) hrdata_nxt = updo;
               upen_nxt  = 1'b0;
               hack_nxt  = 1'b1;
               state_nxt = DONE;
            end else if (cnt == CNT_LAST) begin
               if (rnw) hrdata_nxt = TO_DATA;
               upen_nxt  = 1'b0;
               hack_nxt  = 1'b1;
               herr_nxt  = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt + TOWIDTH'(1);
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      hbusy_nxt = (state_nxt != IDLE);

      hdrop_nxt = hdrop;
      if (hdropclr)
         hdrop_nxt = '0;
      else if (hcs && state != IDLE && hdrop != 8'hFF)
         hdrop_nxt = hdrop + 8'd1;
   end

endmodule

// File: tb/tb_rtlcfg_cpubridge.sv
// Directed bench for rtlcfg_cpubridge: latency-programmable responder, scoreboard of
// expected hrdata/herr per accepted request, timing and drop-counter checks.
module tb_rtlcfg_cpubridge;

   localparam int          TMO = 40;
   localparam logic [31:0] TOV = 32'hDEAD_0BAD;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hcs = 1'b0, hrnw = 1'b0, hdropclr = 1'b0;
   logic [4:0]  haddr = '0;
   logic [31:0] hwdata = '0;
   logic [31:0] hrdata;
   logic        hack, herr, hbusy;
   logic [7:0]  hdrop;
   logic        upen, upws, uprs;
   logic [4:0]  upa;
   logic [31:0] updi;
   logic [31:0] updo = '0;
   logic        uprdy = 1'b0;

   int          checks = 0;
   int          failures = 0;

   int          resp_lat = 5;
   logic [31:0] resp_data = '0;
   logic        resp_xor = 1'b0;
   int          rem = 0;

   logic [32:0] sb[$];
   logic [31:0] last_rd = '0;

   rtlcfg_cpubridge dut (
      .clk(clk), .rst(rst), .hcs(hcs), .hrnw(hrnw), .haddr(haddr), .hwdata(hwdata),
      .hrdata(hrdata), .hack(hack), .herr(herr), .hbusy(hbusy), .hdrop(hdrop),
      .hdropclr(hdropclr), .upen(upen), .upa(upa), .upws(upws), .uprs(uprs),
      .updi(updi), .updo(updo), .uprdy(uprdy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic rnw, input logic [31:0] data, input logic err);
      if (rnw) last_rd = data;
      sb.push_back({last_rd, err});
   endtask

   // Responder: uprdy for one cycle, resp_lat cycles after the strobe cycle.
   always @(posedge clk) begin
      #1;
      uprdy = 1'b0;
      if (rst) rem = 0;
      else if (upws || uprs) rem = resp_lat;
      else if (rem > 0) begin
         rem--;
         if (rem == 0) begin
            uprdy = 1'b1;
            updo  = resp_data ^ (resp_xor ? {27'b0, upa} : 32'b0);
         end
      end
   end

   // Scoreboard: every hack must match the oldest outstanding request.
   always @(posedge clk) begin
      logic [32:0] e;
      #1;
      if (!rst && hack) begin
         chk("sb_expected_hack", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_hrdata", hrdata, e[32:1]);
            chk("sb_herr", herr, e[0]);
         end
      end
   end

   task automatic access(input logic rnw, input logic [4:0] addr, input logic [31:0] wd,
                         input int lat, input logic [31:0] rd, input logic err,
                         input int exp_hack, input string tag);
      int n, en, ws, rs, hk;
      resp_lat = lat; resp_data = rd; resp_xor = 1'b0;
      hrnw = rnw; haddr = addr; hwdata = wd; hcs = 1'b1;
      push_exp(rnw, err ? TOV : rd, err);
      tick;
      hcs = 1'b0;
      n = 1; en = 0; ws = 0; rs = 0; hk = -1;
      while (n < 200) begin
         if (upen) en++;
         if (upws) ws++;
         if (uprs) rs++;
         if (upws || uprs) chk({tag, "_strobe_addr_data"}, {upa, updi}, {addr, wd});
         if (hack) begin
            hk = n;
            chk({tag, "_upen_at_hack"}, upen, 0);
            chk({tag, "_busy_at_hack"}, hbusy, 1);
            break;
         end
         n++;
         tick;
      end
      chk({tag, "_hack_cycle"}, hk, exp_hack);
      chk({tag, "_upen_cycles"}, en, exp_hack - 1);
      chk({tag, "_strobe_counts"}, {ws[7:0], rs[7:0]}, rnw ? 16'h0001 : 16'h0100);
      tick;
      chk({tag, "_after_idle"}, {hbusy, upen, upws, uprs, hack}, 0);
      chk({tag, "_hold_addr_data"}, {upa, updi}, {addr, wd});
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         tick;
         n++;
      end
      chk(tag, sb.size(), 0);
      tick;
   endtask

   initial begin
      int busy, drops;
      tick; tick; tick;
      rst = 1'b0;
      tick;
      chk("reset_outputs", {hrdata, hack, herr, hbusy, hdrop, upen, upa, upws, uprs, updi}, 0);

      access(1'b0, 5'h0A, 32'h1234_5678, 5, 32'h0, 1'b0, 7, "write");
      chk("write_hrdata_unchanged", hrdata, 0);
      access(1'b1, 5'h03, 32'h0, 4, 32'hCAFE_F00D, 1'b0, 6, "read");

      access(1'b1, 5'h1F, 32'h0, TMO + 3, 32'h1111_2222, 1'b1, TMO + 2, "timeout");
      tick; tick; tick;
      chk("late_uprdy_ignored", {hack, hbusy, upen}, 0);
      chk("late_uprdy_hrdata", hrdata, TOV);

      access(1'b1, 5'h07, 32'h0, TMO, 32'h5A5A_1234, 1'b0, TMO + 2, "race");

      resp_lat = 5; resp_data = 32'h1000_0000; resp_xor = 1'b1;
      busy = 0; drops = 0;
      for (int i = 0; i < 300; i++) begin
         hcs = 1'b1; hrnw = 1'b1; haddr = i[4:0]; hwdata = i;
         if (busy == 0) begin
            push_exp(1'b1, 32'h1000_0000 ^ {27'b0, i[4:0]}, 1'b0);
            busy = resp_lat + 2;
         end else begin
            busy--;
            drops++;
         end
         tick;
      end
      hcs = 1'b0;
      chk("drop_saturate", hdrop, drops > 255 ? 255 : drops);
      drain("drop_drain_in_order");

      resp_lat = 3; resp_xor = 1'b0;
      hrnw = 1'b0; haddr = 5'h09; hwdata = 32'h77; hcs = 1'b1;
      push_exp(1'b0, 32'h0, 1'b0);
      tick;
      hdropclr = 1'b1;
      tick;
      chk("clr_beats_drop", hdrop, 0);
      hdropclr = 1'b0;
      tick;
      chk("drop_after_clr", hdrop, 1);
      hcs = 1'b0;
      drain("clr_drain");

      resp_lat = 10; hrnw = 1'b1; haddr = 5'h02; hcs = 1'b1;
      tick;
      hcs = 1'b0;
      tick; tick;
      rst = 1'b1;
      sb.delete();
      last_rd = '0;
      tick;
      chk("midwait_reset_outputs", {hrdata, hack, herr, hbusy, hdrop, upen, upa, upws, uprs, updi}, 0);
      rst = 1'b0;
      tick;
      chk("after_reset_quiet", {hack, hbusy, upen}, 0);
      access(1'b0, 5'h15, 32'hA5A5_0F0F, 5, 32'h0, 1'b0, 7, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
